// File: rtl/evb_result_sink.sv
// Result sink behind the EVB controller: captures per-point result/status pairs
// into a show-ahead FIFO, drains them over valid/ready and flags batch completion.
module evb_result_sink #(
  parameter int DEPTH = 32,
  parameter int LVL_W = $clog2(DEPTH) + 1,
  parameter int CNT_W = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             batch_start,
  input  logic             done_evp,
  input  logic             done_evb,
  input  logic [31:0]      result,
  input  logic [31:0]      status,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [31:0]      out_result,
  output logic [31:0]      out_status,
  output logic             batch_done,
  output logic [CNT_W-1:0] result_count,
  output logic             overflow,
  output logic [LVL_W-1:0] fifo_level
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [31:0] status;
    logic [31:0] result;
  } entry_t;

  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, DONE} state_t;

  state_t           state, state_nxt;
  entry_t           mem [DEPTH];
  entry_t           head;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [LVL_W-1:0] level, level_nxt;
  logic             evp_q;
  logic             cap, abort, push_req, push, pop, full, drop;

  // A held done_evp level is one event; only the rising edge captures.
  assign cap      = done_evp & ~evp_q;
  assign abort    = batch_start & (state != IDLE);
  assign push_req = cap & (state == COLLECT) & ~batch_start;
  assign full     = (level == LVL_W'(DEPTH));
  assign pop      = out_valid & out_ready & ~abort;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign push     = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;

  assign level_nxt = abort ? '0 : level + LVL_W'(push) - LVL_W'(pop);

  assign head       = mem[rd_ptr];
  assign out_valid  = (level != '0);
  assign out_result = out_valid ? head.result : '0;
  assign out_status = out_valid ? head.status : '0;
  assign fifo_level = level;

  always_comb begin
    state_nxt  = state;
    batch_done = 1'b0;
    case (state)
      IDLE:    if (batch_start) state_nxt = COLLECT;
      COLLECT: if (done_evb) state_nxt = DRAIN;
      DRAIN:   if (level_nxt == '0) state_nxt = DONE;
      DONE: begin
        batch_done = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = COLLECT;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      evp_q        <= 1'b0;
      level        <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      result_count <= '0;
      overflow     <= 1'b0;
    end else begin
      state <= state_nxt;
      evp_q <= done_evp;
      level <= level_nxt;
      if (abort) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      end
      // Count and flag survive DONE and clear only when a new batch opens.
      if (batch_start) begin
        result_count <= '0;
        overflow     <= 1'b0;
      end else begin
        if (push && (result_count != '1)) result_count <= result_count + CNT_W'(1);
        if (drop) overflow <= 1'b1;
      end
    end
  end

  // Storage carries no reset; validity is tracked by level alone.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{status: status, result: result};
  end

endmodule

// File: tb/tb_evb_result_sink.sv
// Bench for evb_result_sink: directed scenarios plus randomized batches checked
// against a queue-based model of the sink.
module tb_evb_result_sink;
  localparam int DEPTH = 32;
  localparam int LVL_W = 6;
  localparam int CNT_W = 11;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             batch_start = 1'b0, done_evp = 1'b0, done_evb = 1'b0, out_ready = 1'b0;
  logic [31:0]      result = '0, status = '0;
  logic             out_valid, batch_done, overflow;
  logic [31:0]      out_result, out_status;
  logic [CNT_W-1:0] result_count;
  logic [LVL_W-1:0] fifo_level;

  int n_pass = 0;
  int n_total = 0;

  evb_result_sink #(.DEPTH(DEPTH), .LVL_W(LVL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .batch_start(batch_start), .done_evp(done_evp),
    .done_evb(done_evb), .result(result), .status(status), .out_ready(out_ready),
    .out_valid(out_valid), .out_result(out_result), .out_status(out_status),
    .batch_done(batch_done), .result_count(result_count), .overflow(overflow),
    .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    batch_start = 0; done_evp = 0; done_evb = 0; out_ready = 0; result = 0; status = 0;
    rst = 0;
    step();
    step();
    rst = 1;
    step();
  endtask

  task automatic pulse(input logic [31:0] r, input logic [31:0] s);
    result = r; status = s; done_evp = 1;
    step();
    done_evp = 0;
    step();
  endtask

  task automatic open_batch();
    batch_start = 1;
    step();
    batch_start = 0;
  endtask

  task automatic test_reset();
    batch_start = 0; done_evp = 0; done_evb = 0; out_ready = 0; rst = 0;
    #2;
    n_total++; if (out_valid !== 1'b0 || fifo_level !== '0) $display("FAIL reset_fifo valid=%0b level=%0d exp 0/0", out_valid, fifo_level); else n_pass++;
    n_total++; if (out_result !== '0 || out_status !== '0) $display("FAIL reset_data res=%h sts=%h exp 0/0", out_result, out_status); else n_pass++;
    n_total++; if (result_count !== '0 || overflow !== 1'b0 || batch_done !== 1'b0) $display("FAIL reset_flags cnt=%0d ovf=%0b bd=%0b exp 0/0/0", result_count, overflow, batch_done); else n_pass++;
    step();
    rst = 1;
    step();
  endtask

  task automatic test_basic();
    int bd = 0;
    logic [31:0] vals [3] = '{32'h11, 32'h22, 32'h33};
    apply_reset();
    out_ready = 1;
    open_batch();
    for (int i = 0; i < 3; i++) begin
      result = vals[i]; status = 0; done_evp = 1;
      step();
      n_total++; if (out_valid !== 1'b1 || out_result !== vals[i]) $display("FAIL basic_head%0d valid=%0b res=%h exp 1/%h", i, out_valid, out_result, vals[i]); else n_pass++;
      done_evp = 0;
      step();
    end
    n_total++; if (out_valid !== 1'b0 || out_result !== '0) $display("FAIL basic_empty valid=%0b res=%h exp 0/0", out_valid, out_result); else n_pass++;
    done_evb = 1;
    step();
    done_evb = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (batch_done === 1'b1) bd++;
    end
    n_total++; if (bd != 1) $display("FAIL basic_done_pulses got=%0d exp 1", bd); else n_pass++;
    n_total++; if (result_count !== 11'd3 || overflow !== 1'b0) $display("FAIL basic_count cnt=%0d ovf=%0b exp 3/0", result_count, overflow); else n_pass++;
  endtask

  task automatic test_overflow();
    bit ok_seq = 1, early_done = 0;
    apply_reset();
    open_batch();
    for (int i = 0; i < 33; i++) pulse(32'h100 + i, 32'h900 + i);
    n_total++; if (fifo_level !== 6'd32 || overflow !== 1'b1 || result_count !== 11'd32) $display("FAIL ovf_fill level=%0d ovf=%0b cnt=%0d exp 32/1/32", fifo_level, overflow, result_count); else n_pass++;
    done_evb = 1;
    step();
    done_evb = 0;
    step();
    step();
    n_total++; if (batch_done !== 1'b0) $display("FAIL ovf_no_early_done bd=%0b exp 0", batch_done); else n_pass++;
    out_ready = 1;
    for (int i = 0; i < 32; i++) begin
      if (out_result !== 32'h100 + i || out_status !== 32'h900 + i) ok_seq = 0;
      if (batch_done !== 1'b0) early_done = 1;
      step();
    end
    n_total++; if (!ok_seq || early_done) $display("FAIL ovf_drain_order in_order=%0b early_done=%0b exp 1/0", ok_seq, early_done); else n_pass++;
    n_total++; if (batch_done !== 1'b1 || fifo_level !== '0) $display("FAIL ovf_done bd=%0b level=%0d exp 1/0", batch_done, fifo_level); else n_pass++;
    step();
    n_total++; if (batch_done !== 1'b0 || result_count !== 11'd32 || overflow !== 1'b1) $display("FAIL ovf_hold bd=%0b cnt=%0d ovf=%0b exp 0/32/1", batch_done, result_count, overflow); else n_pass++;
    out_ready = 0;
  endtask

  task automatic test_full_push_pop();
    apply_reset();
    open_batch();
    for (int i = 0; i < 32; i++) pulse(32'h200 + i, 32'h0);
    result = 32'hABC; status = 32'h5; done_evp = 1; out_ready = 1;
    step();
    done_evp = 0; out_ready = 0;
    n_total++; if (fifo_level !== 6'd32 || overflow !== 1'b0 || result_count !== 11'd33) $display("FAIL full_pp level=%0d ovf=%0b cnt=%0d exp 32/0/33", fifo_level, overflow, result_count); else n_pass++;
    n_total++; if (out_result !== 32'h201) $display("FAIL full_pp_head res=%h exp 201", out_result); else n_pass++;
    out_ready = 1;
    for (int i = 0; i < 31; i++) step();
    out_ready = 0;
    n_total++; if (out_result !== 32'hABC || out_status !== 32'h5 || fifo_level !== 6'd1) $display("FAIL full_pp_tail res=%h sts=%h level=%0d exp abc/5/1", out_result, out_status, fifo_level); else n_pass++;
  endtask

  task automatic test_held_high();
    apply_reset();
    open_batch();
    done_evp = 1;
    for (int k = 0; k < 5; k++) begin
      result = 32'h50 + k;
      step();
    end
    done_evp = 0;
    step();
    n_total++; if (fifo_level !== 6'd1 || result_count !== 11'd1 || out_result !== 32'h50) $display("FAIL held_high level=%0d cnt=%0d res=%h exp 1/1/50", fifo_level, result_count, out_result); else n_pass++;
  endtask

  task automatic test_abort();
    int bd = 0;
    apply_reset();
    open_batch();
    for (int i = 0; i < 4; i++) pulse(32'h60 + i, 32'h1);
    n_total++; if (fifo_level !== 6'd4) $display("FAIL abort_pre level=%0d exp 4", fifo_level); else n_pass++;
    batch_start = 1; done_evp = 1; result = 32'hDEAD;
    step();
    batch_start = 0; done_evp = 0;
    n_total++; if (out_valid !== 1'b0 || fifo_level !== '0 || result_count !== '0 || batch_done !== 1'b0) $display("FAIL abort_flush valid=%0b level=%0d cnt=%0d bd=%0b exp 0/0/0/0", out_valid, fifo_level, result_count, batch_done); else n_pass++;
    step();
    pulse(32'h31, 32'h0);
    pulse(32'h32, 32'h0);
    n_total++; if (fifo_level !== 6'd2 || result_count !== 11'd2 || out_result !== 32'h31) $display("FAIL abort_rebatch level=%0d cnt=%0d res=%h exp 2/2/31", fifo_level, result_count, out_result); else n_pass++;
    out_ready = 1;
    step();
    n_total++; if (out_result !== 32'h32) $display("FAIL abort_second res=%h exp 32", out_result); else n_pass++;
    done_evb = 1;
    step();
    done_evb = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (batch_done === 1'b1) bd++;
    end
    n_total++; if (bd != 1) $display("FAIL abort_done_pulses got=%0d exp 1", bd); else n_pass++;
    out_ready = 0;
  endtask

  task automatic test_async_reset();
    int bd = 0;
    apply_reset();
    open_batch();
    for (int i = 0; i < 3; i++) pulse(32'h70 + i, 32'h7);
    done_evb = 1;
    step();
    done_evb = 0;
    n_total++; if (fifo_level !== 6'd3 || out_status !== 32'h7) $display("FAIL arst_pre level=%0d sts=%h exp 3/7", fifo_level, out_status); else n_pass++;
    #3 rst = 0;
    #1;
    n_total++; if (out_valid !== 1'b0 || fifo_level !== '0 || out_result !== '0 || out_status !== '0 || result_count !== '0 || batch_done !== 1'b0) $display("FAIL arst_now valid=%0b level=%0d res=%h sts=%h cnt=%0d bd=%0b exp all 0", out_valid, fifo_level, out_result, out_status, result_count, batch_done); else n_pass++;
    step();
    rst = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (batch_done === 1'b1) bd++;
    end
    pulse(32'h99, 32'h0);
    n_total++; if (bd != 0 || fifo_level !== '0) $display("FAIL arst_idle bd=%0d level=%0d exp 0/0", bd, fifo_level); else n_pass++;
  endtask

  task automatic test_random();
    logic [63:0] q [$];
    int phase = 0;   // 0 idle, 1 collect, 2 drain, 3 done
    int cnt = 0;
    bit ovf = 0, prev = 0, ev, popm, full;
    logic [31:0] r, s;
    apply_reset();
    for (int b = 0; b < 6; b++) begin
      for (int c = 0; c < 200; c++) begin
        r = $urandom; s = $urandom;
        batch_start = (c == 0) || ($urandom % 150 == 0);
        done_evp = $urandom % 2;
        done_evb = (c >= 60 && c < 64) || ($urandom % 50 == 0);
        out_ready = (b % 2) ? ($urandom % 3 == 0) : ($urandom % 4 != 0);
        result = r; status = s;
        ev = done_evp && !prev;
        prev = done_evp;
        popm = (q.size() != 0) && out_ready;
        if (batch_start && phase != 0) begin
          q.delete(); cnt = 0; ovf = 0; phase = 1;
        end else begin
          full = (q.size() == DEPTH);
          if (popm) q.delete(0);
          if (ev && phase == 1) begin
            if (!full || popm) begin
              q.push_back({s, r});
              if (cnt < 2047) cnt++;
            end else ovf = 1;
          end
          case (phase)
            0: if (batch_start) begin phase = 1; cnt = 0; ovf = 0; end
            1: if (done_evb) phase = 2;
            2: if (q.size() == 0) phase = 3;
            default: phase = 0;
          endcase
        end
        step();
        n_total++; if (fifo_level !== LVL_W'(q.size()) || out_valid !== (q.size() != 0)) $display("FAIL rnd_level b=%0d c=%0d level=%0d valid=%0b exp %0d", b, c, fifo_level, out_valid, q.size()); else n_pass++;
        n_total++; if (q.size() != 0 ? (out_result !== q[0][31:0] || out_status !== q[0][63:32]) : (out_result !== '0 || out_status !== '0))
          $display("FAIL rnd_head b=%0d c=%0d res=%h sts=%h exp %h", b, c, out_result, out_status, (q.size() != 0) ? q[0] : 64'h0); else n_pass++;
        n_total++; if (result_count !== CNT_W'(cnt) || overflow !== ovf || batch_done !== (phase == 3)) $display("FAIL rnd_flags b=%0d c=%0d cnt=%0d ovf=%0b bd=%0b exp %0d/%0b/%0b", b, c, result_count, overflow, batch_done, cnt, ovf, phase == 3); else n_pass++;
      end
    end
    batch_start = 0; done_evp = 0; done_evb = 0; out_ready = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_full_push_pop();
    test_held_high();
    test_abort();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule
